// File: rtl/spi_arb_pkg.sv
// Shared types and defaults for the SPI command arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Holds the arbiter state encoding and the default frame length and
// launch-to-completion timeout used by spi_cmd_arbiter.
package spi_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LAUNCH  = 3'd1,
    ST_XFER    = 3'd2,
    ST_DONE    = 3'd3,
    ST_RECOVER = 3'd4
  } arb_state_e;

  localparam int          DEF_LEN_CMD     = 32;
  localparam logic [15:0] DEF_TIMEOUT_CYC = 16'd20000;

endpackage

// File: rtl/spi_cmd_arbiter_rr_pick.sv
// Combinational round-robin picker over an N-bit request vector.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; caller decides when to act on the pick.
//
// Ports:
//   req  - request vector
//   ptr  - highest-priority index this round
//   gnt  - one-hot grant (first set req at or after ptr, wrapping)
//   idx  - binary index of gnt
//   vld  - any request set
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          vld
);

  // One extra bit so ptr + offset cannot overflow before the wrap.
  logic [IW:0] slot;

  always_comb begin
    gnt  = '0;
    idx  = '0;
    vld  = 1'b0;
    slot = '0;
    for (int k = 0; k < N; k++) begin
      slot = {1'b0, ptr} + (IW+1)'(k);
      if (slot >= (IW+1)'(N)) begin
        slot = slot - (IW+1)'(N);
      end
      if (!vld && req[slot[IW-1:0]]) begin
        vld                = 1'b1;
        gnt[slot[IW-1:0]]  = 1'b1;
        idx                = slot[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/spi_cmd_arbiter.sv
// Round-robin scheduler sharing one SPI master between NUM_REQ requesters.
// Latency: REQ->GNT 1 cycle; CSN rise->DONE 3 cycles; DONE->next GNT >= 1 idle cycle.
// Backpressure: REQ is a held level; only one transaction in flight, others wait in REQ.
//
// Ports:
//   CLK, RST_N           - clock, asynchronous active-low reset
//   REQ, REQ_CMD         - per-requester request level and packed 32-bit commands
//   GNT, DONE            - one-hot single-cycle accept / completion pulses
//   RDATA, ERR, BUSY     - response word (held to next DONE), timeout flag, in-flight
//   M_START, M_CMD       - to SPI master START / SPI_CMD
//   M_CSN, M_MISO_DATA   - from SPI master (CSN is asynchronous to CLK)
// Build option: define SPI_ARB_TIMEOUT_EN to add the launch-to-completion
// timeout (counter + RECOVER state); otherwise ERR is tied low.
module spi_cmd_arbiter
  import spi_arb_pkg::*;
#(
  parameter int          NUM_REQ     = 4,
  parameter int          LEN_CMD     = DEF_LEN_CMD,
  parameter logic [15:0] TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic [NUM_REQ-1:0]         REQ,
  input  logic [NUM_REQ*LEN_CMD-1:0] REQ_CMD,
  output logic [NUM_REQ-1:0]         GNT,
  output logic [NUM_REQ-1:0]         DONE,
  output logic [LEN_CMD-1:0]         RDATA,
  output logic                       ERR,
  output logic                       BUSY,
  output logic                       M_START,
  output logic [LEN_CMD-1:0]         M_CMD,
  input  logic                       M_CSN,
  input  logic [LEN_CMD-1:0]         M_MISO_DATA
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // CSN synchronizer, preset high so an idle master reads as "not selected".
  logic csn_meta_q;
  logic csn_s_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      csn_meta_q <= 1'b1;
      csn_s_q    <= 1'b1;
    end else begin
      csn_meta_q <= M_CSN;
      csn_s_q    <= csn_meta_q;
    end
  end

  arb_state_e           state_q, state_d;
  logic [PW-1:0]        ptr_q, ptr_d;
  logic [PW-1:0]        owner_q, owner_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic [LEN_CMD-1:0]   rdata_q, rdata_d;
  logic                 busy_q, busy_d;
  logic                 m_start_q, m_start_d;
  logic [LEN_CMD-1:0]   m_cmd_q, m_cmd_d;

  logic [NUM_REQ-1:0]   pick_gnt;
  logic [PW-1:0]        pick_idx;
  logic                 pick_vld;
  logic [LEN_CMD-1:0]   pick_cmd;
  logic [PW-1:0]        ptr_nxt;
  logic [NUM_REQ-1:0]   owner_oh;

  rr_pick #(
    .N  (NUM_REQ),
    .IW (PW)
  ) u_rr_pick (
    .req (REQ),
    .ptr (ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .vld (pick_vld)
  );

  always_comb begin
    pick_cmd = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_gnt[i]) begin
        pick_cmd = REQ_CMD[i*LEN_CMD +: LEN_CMD];
      end
    end
  end

  assign ptr_nxt = (pick_idx == PW'(NUM_REQ - 1)) ? '0 : pick_idx + PW'(1);

  always_comb begin
    owner_oh          = '0;
    owner_oh[owner_q] = 1'b1;
  end

`ifdef SPI_ARB_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;
  logic        err_q, err_d;
  logic        tmo_hit;

  assign tmo_hit = (cnt_q == TIMEOUT_CYC - 16'd1);
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYC;
`endif

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    gnt_d     = '0;
    done_d    = '0;
    rdata_d   = rdata_q;
    busy_d    = busy_q;
    m_start_d = m_start_q;
    m_cmd_d   = m_cmd_q;
`ifdef SPI_ARB_TIMEOUT_EN
    err_d     = 1'b0;
    cnt_d     = cnt_q;
`endif

    case (state_q)
      ST_IDLE: begin
        // Only launch when the master has visibly released CSN.
        if (pick_vld && csn_s_q) begin
          gnt_d     = pick_gnt;
          owner_d   = pick_idx;
          m_cmd_d   = pick_cmd;
          m_start_d = 1'b1;
          busy_d    = 1'b1;
          ptr_d     = ptr_nxt;
          state_d   = ST_LAUNCH;
`ifdef SPI_ARB_TIMEOUT_EN
          cnt_d     = '0;
`endif
        end
      end

      ST_LAUNCH: begin
        // START stays up until the slow SCK-domain FSM has visibly taken it.
        if (!csn_s_q) begin
          m_start_d = 1'b0;
          state_d   = ST_XFER;
`ifdef SPI_ARB_TIMEOUT_EN
        end else if (tmo_hit) begin
          m_start_d = 1'b0;
          state_d   = ST_RECOVER;
        end else begin
          cnt_d     = cnt_q + 16'd1;
`endif
        end
      end

      ST_XFER: begin
        // The master settles MISO data before raising CSN, so it is safe to
        // capture once the synchronized CSN reads high.
        if (csn_s_q) begin
          done_d  = owner_oh;
          rdata_d = M_MISO_DATA;
          state_d = ST_DONE;
`ifdef SPI_ARB_TIMEOUT_EN
        end else if (tmo_hit) begin
          state_d = ST_RECOVER;
        end else begin
          cnt_d   = cnt_q + 16'd1;
`endif
        end
      end

      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end

`ifdef SPI_ARB_TIMEOUT_EN
      ST_RECOVER: begin
        if (csn_s_q) begin
          done_d  = owner_oh;
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = ST_DONE;
        end
      end
`endif

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      owner_q   <= '0;
      gnt_q     <= '0;
      done_q    <= '0;
      rdata_q   <= '0;
      busy_q    <= 1'b0;
      m_start_q <= 1'b0;
      m_cmd_q   <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      rdata_q   <= rdata_d;
      busy_q    <= busy_d;
      m_start_q <= m_start_d;
      m_cmd_q   <= m_cmd_d;
    end
  end

`ifdef SPI_ARB_TIMEOUT_EN
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign ERR = err_q;
`else
  assign ERR = 1'b0;
`endif

  assign GNT     = gnt_q;
  assign DONE    = done_q;
  assign RDATA   = rdata_q;
  assign BUSY    = busy_q;
  assign M_START = m_start_q;
  assign M_CMD   = m_cmd_q;

endmodule

// File: tb/tb_spi_cmd_arbiter.sv
// Bench for spi_cmd_arbiter: table of single transactions, hand sequences for
// contention / START hold / reset / timeout, then random traffic checked by a
// round-robin scoreboard and a behavioural SPI master model.
module tb_spi_cmd_arbiter;

  localparam int          N  = 4;
  localparam int          L  = 32;
  localparam logic [15:0] TO = 16'd100;

  logic           CLK;
  logic           RST_N;
  logic [N-1:0]   REQ;
  logic [N*L-1:0] REQ_CMD;
  logic [N-1:0]   GNT;
  logic [N-1:0]   DONE;
  logic [L-1:0]   RDATA;
  logic           ERR;
  logic           BUSY;
  logic           M_START;
  logic [L-1:0]   M_CMD;
  logic           M_CSN;
  logic [L-1:0]   M_MISO_DATA;

  spi_cmd_arbiter #(
    .NUM_REQ     (N),
    .LEN_CMD     (L),
    .TIMEOUT_CYC (TO)
  ) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .REQ         (REQ),
    .REQ_CMD     (REQ_CMD),
    .GNT         (GNT),
    .DONE        (DONE),
    .RDATA       (RDATA),
    .ERR         (ERR),
    .BUSY        (BUSY),
    .M_START     (M_START),
    .M_CMD       (M_CMD),
    .M_CSN       (M_CSN),
    .M_MISO_DATA (M_MISO_DATA)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Slave device behaviour: fixed answer for the directed command, otherwise
  // a simple reversible scramble of the command.
  function automatic logic [31:0] resp_of(input logic [31:0] cmd);
    if (cmd == 32'hA5A5_0001) return 32'h1234_5678;
    return {cmd[15:0], cmd[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  // Round-robin rule: first set request at or after ptr, wrapping.
  function automatic int model_pick(input logic [N-1:0] req, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (req[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic int oh2idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) begin
      if (v[i]) return i;
    end
    return -1;
  endfunction

  // ---------------- SPI master model ----------------
  int          mst_phase, mst_cnt, cur_dly, cur_len;
  int          mst_dly  = 6;
  int          mst_len  = 40;
  bit          mst_hang = 1'b0;
  bit          mst_rand = 1'b0;
  logic [31:0] mst_cmd;

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      M_CSN       <= 1'b1;
      M_MISO_DATA <= '0;
      mst_phase   <= 0;
      mst_cnt     <= 0;
      mst_cmd     <= '0;
      cur_dly     <= 1;
      cur_len     <= 1;
    end else begin
      case (mst_phase)
        0: if (M_START) begin
          mst_cmd   <= M_CMD;
          mst_cnt   <= 0;
          cur_dly   <= mst_rand ? int'($urandom_range(30, 2)) : mst_dly;
          cur_len   <= mst_rand ? int'($urandom_range(40, 5)) : mst_len;
          mst_phase <= 1;
        end
        1: if (!mst_hang) begin
          if (mst_cnt >= cur_dly - 1) begin
            M_CSN     <= 1'b0;
            mst_cnt   <= 0;
            mst_phase <= 2;
          end else begin
            mst_cnt <= mst_cnt + 1;
          end
        end
        2: if (mst_cnt >= cur_len - 1) begin
          M_MISO_DATA <= resp_of(mst_cmd);
          mst_phase   <= 3;
        end else begin
          mst_cnt <= mst_cnt + 1;
        end
        3: begin
          M_CSN     <= 1'b1;
          mst_phase <= 4;
        end
        default: if (!M_START) mst_phase <= 0;
      endcase
    end
  end

  // ---------------- scoreboard state ----------------
  logic [N-1:0]   prev_req;
  logic [N*L-1:0] prev_cmd;
  logic [N-1:0]   mon_exp;
  logic [31:0]    exp_cmd;
  int             mdl_ptr, exp_owner, mon_pick;
  int             n_gnt = 0;
  bit             inflight = 1'b0;
  bit             expect_timeout = 1'b0;

  task automatic monitor();
    forever begin
      @(negedge CLK);
      if (!RST_N) begin
        mdl_ptr  = 0;
        inflight = 1'b0;
        prev_req = '0;
        prev_cmd = '0;
      end else begin
        if (GNT != '0) begin
          mon_pick = model_pick(prev_req, mdl_ptr);
          mon_exp  = '0;
          if (mon_pick >= 0) mon_exp[mon_pick] = 1'b1;
          chk("mon_gnt", GNT, mon_exp);
          chk("mon_one_in_flight", inflight, 0);
          if (mon_pick >= 0) begin
            mdl_ptr   = (mon_pick + 1) % N;
            exp_owner = mon_pick;
            exp_cmd   = prev_cmd[mon_pick*L +: L];
          end
          inflight = 1'b1;
          n_gnt++;
        end
        if (inflight) chk("mon_m_cmd_hold", M_CMD, exp_cmd);
        if (DONE != '0) begin
          mon_exp            = '0;
          mon_exp[exp_owner] = 1'b1;
          chk("mon_done_owner", DONE, mon_exp);
          chk("mon_done_in_flight", inflight, 1);
          chk("mon_rdata", RDATA, expect_timeout ? 32'h0 : resp_of(exp_cmd));
          chk("mon_err", ERR, expect_timeout);
          inflight = 1'b0;
        end
        prev_req = REQ;
        prev_cmd = REQ_CMD;
      end
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    REQ   = '0;
    repeat (3) @(posedge CLK);
    #1;
    RST_N = 1'b1;
    tick();
  endtask

  task automatic wait_done(input int limit);
    int w;
    w = 0;
    while (DONE == '0 && w < limit) begin
      tick();
      w++;
    end
  endtask

  task automatic run_txn(input logic [N-1:0] req, input logic [N*L-1:0] cmds, input int idx);
    logic [N-1:0] exp_oh;
    logic [31:0]  exp_c;
    exp_oh      = '0;
    exp_oh[idx] = 1'b1;
    exp_c       = cmds[idx*L +: L];
    REQ         = req;
    REQ_CMD     = cmds;
    tick();
    chk("tbl_gnt", GNT, exp_oh);
    chk("tbl_m_cmd", M_CMD, exp_c);
    chk("tbl_busy_at_gnt", BUSY, 1);
    REQ = '0;
    wait_done(3000);
    chk("tbl_done", DONE, exp_oh);
    chk("tbl_rdata", RDATA, resp_of(exp_c));
    chk("tbl_m_cmd_at_done", M_CMD, exp_c);
    tick();
    chk("tbl_idle_busy", BUSY, 0);
  endtask

  typedef struct {
    logic [N-1:0] req;
    int           idx;
  } vec_t;

  vec_t           tbl[10];
  logic [N*L-1:0] cmds;
  int             order[5];
  int             grants, low, n, w;
  bit             hold_ok;

  initial begin
    REQ     = '0;
    REQ_CMD = '0;
    RST_N   = 1'b0;
    fork
      monitor();
    join_none

    // Pointer evolution from reset: 0 ->3 ->0 ->1 ->2 ->1 ->1 ->2 ->3 ->0 ->1
    tbl[0] = '{req: 4'b0100, idx: 2};
    tbl[1] = '{req: 4'b1111, idx: 3};
    tbl[2] = '{req: 4'b1001, idx: 0};
    tbl[3] = '{req: 4'b1010, idx: 1};
    tbl[4] = '{req: 4'b0011, idx: 0};
    tbl[5] = '{req: 4'b0001, idx: 0};
    tbl[6] = '{req: 4'b0110, idx: 1};
    tbl[7] = '{req: 4'b0110, idx: 2};
    tbl[8] = '{req: 4'b1000, idx: 3};
    tbl[9] = '{req: 4'b0001, idx: 0};
    order  = '{0, 1, 2, 3, 0};

    // Reset values
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_gnt", GNT, 0);
    chk("rst_done", DONE, 0);
    chk("rst_rdata", RDATA, 0);
    chk("rst_err", ERR, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_m_start", M_START, 0);
    chk("rst_m_cmd", M_CMD, 0);
    RST_N = 1'b1;
    tick();

    // Directed single transactions, including the 3 -> 0 pointer wrap
    for (int t = 0; t < 10; t++) begin
      for (int i = 0; i < N; i++) cmds[i*L +: L] = $urandom;
      if (t == 0) cmds[2*L +: L] = 32'hA5A5_0001;
      run_txn(tbl[t].req, cmds, tbl[t].idx);
    end

    // START held through a long CSN delay
    mst_dly = 800;
    for (int i = 0; i < N; i++) cmds[i*L +: L] = $urandom;
    REQ     = 4'b0010;
    REQ_CMD = cmds;
    tick();
    chk("hold_gnt", GNT, 4'b0010);
    REQ     = '0;
    hold_ok = 1'b1;
    w       = 0;
    while (M_CSN && w < 2000) begin
      if (!M_START) hold_ok = 1'b0;
      tick();
      w++;
    end
    chk("hold_start_high", hold_ok, 1);
    n = 0;
    while (M_START && n < 10) begin
      tick();
      n++;
    end
    chk("hold_start_drop_within_3", (n >= 1 && n <= 3), 1);
    wait_done(3000);
    chk("hold_done", DONE, 4'b0010);
    tick();
    mst_dly = 6;

    // Reset in the middle of a transfer; pointer must come back to 0
    REQ = 4'b0100;
    tick();
    chk("rmid_gnt", GNT, 4'b0100);
    REQ = '0;
    w   = 0;
    while (M_CSN && w < 200) begin
      tick();
      w++;
    end
    repeat (4) tick();
    RST_N = 1'b0;
    #1;
    chk("rmid_gnt0", GNT, 0);
    chk("rmid_done0", DONE, 0);
    chk("rmid_rdata0", RDATA, 0);
    chk("rmid_err0", ERR, 0);
    chk("rmid_busy0", BUSY, 0);
    chk("rmid_start0", M_START, 0);
    chk("rmid_mcmd0", M_CMD, 0);
    repeat (2) tick();
    RST_N = 1'b1;
    tick();
    for (int i = 0; i < N; i++) cmds[i*L +: L] = $urandom;
    run_txn(4'b1010, cmds, 1);

    // Full contention from reset: 0,1,2,3,0 with a single idle BUSY cycle
    do_reset();
    for (int i = 0; i < N; i++) cmds[i*L +: L] = $urandom;
    REQ_CMD = cmds;
    REQ     = 4'b1111;
    grants  = 0;
    low     = 0;
    for (int c = 0; c < 5000 && grants < 5; c++) begin
      tick();
      if (GNT != '0) begin
        chk("cont_order", oh2idx(GNT), order[grants]);
        if (grants > 0) chk("cont_busy_gap", low, 1);
        grants++;
        low = 0;
      end else if (!BUSY) begin
        low++;
      end
    end
    chk("cont_grants", grants, 5);
    REQ = '0;
    wait_done(3000);
    tick();

    // Random traffic against the scoreboard
    mst_rand = 1'b1;
    n        = n_gnt;
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (GNT[i]) begin
          REQ[i] = 1'b0;
        end else if (REQ[i] && $urandom_range(99, 0) == 0) begin
          REQ[i] = 1'b0;
        end else if (!REQ[i] && $urandom_range(29, 0) == 0) begin
          REQ[i]             = 1'b1;
          REQ_CMD[i*L +: L]  = $urandom;
        end
      end
      tick();
    end
    REQ = '0;
    w   = 0;
    while ((inflight || BUSY) && w < 3000) begin
      tick();
      w++;
    end
    chk("rand_drained", inflight, 0);
    chk("rand_activity", (n_gnt - n) > 20, 1);
    mst_rand = 1'b0;

`ifdef SPI_ARB_TIMEOUT_EN
    // Master never responds: START drops after TIMEOUT_CYC, then ERR completion
    do_reset();
    mst_hang       = 1'b1;
    expect_timeout = 1'b1;
    REQ            = 4'b0001;
    tick();
    chk("tmo_gnt", GNT, 4'b0001);
    REQ = '0;
    n   = 0;
    while (M_START && n < 1000) begin
      tick();
      n++;
    end
    chk("tmo_start_drop_cycle", n, 100);
    wait_done(1000);
    chk("tmo_done", DONE, 4'b0001);
    chk("tmo_err", ERR, 1);
    chk("tmo_rdata", RDATA, 0);
    tick();
    expect_timeout = 1'b0;
    mst_hang       = 1'b0;
    do_reset();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
